// File: rtl/sprite_anim_blitter_if.sv
// rtl/sprite_anim_blitter_if.sv - sprite ROM and palette bus between a blitter and its assets
// master: the blitter (drives rom_address, pal_index; receives rom_q, palette_*)
// slave : the external ROM/palette (receives rom_address, pal_index; drives rom_q, palette_*)
interface sprite_anim_blitter_if #(
    parameter int ADDR_W = 12,
    parameter int IDX_W  = 4
);
    logic [ADDR_W-1:0] rom_address;
    logic [IDX_W-1:0]  rom_q;
    logic [IDX_W-1:0]  pal_index;
    logic [3:0]        palette_red;
    logic [3:0]        palette_green;
    logic [3:0]        palette_blue;

    modport master (
        output rom_address,
        output pal_index,
        input  rom_q,
        input  palette_red,
        input  palette_green,
        input  palette_blue
    );

    modport slave (
        input  rom_address,
        input  pal_index,
        output rom_q,
        output palette_red,
        output palette_green,
        output palette_blue
    );
endinterface

// File: rtl/sprite_anim_blitter.sv
// rtl/sprite_anim_blitter.sv - animated, scaled, mirrorable sprite blitter for the VGA pixel path
// Ports:
//   vga_clk, reset_n          pixel clock, asynchronous active-low reset
//   DrawX, DrawY, blank       pixel position and active-video flag from the timing generator
//   frame_start               one-cycle pulse at the start of vertical blanking
//   pos_x, pos_y, flip_h      live sprite placement and horizontal mirror
//   anim_en, anim_restart     animation advance enable and return-to-frame-0
//   bus                       ROM address/data and palette lookup (master side)
//   red, green, blue          registered pixel colour
//   sprite_on                 registered: opaque sprite pixel present
//   frame_idx                 current animation frame
module sprite_anim_blitter #(
    parameter int SPR_W           = 32,
    parameter int SPR_H           = 32,
    parameter int NUM_FRAMES      = 4,
    parameter int SCALE_LOG2      = 1,
    parameter int FRAME_HOLD      = 8,
    parameter int IDX_W           = 4,
    parameter int TRANSPARENT_IDX = 0,
    parameter int ROM_LATENCY     = 1,
    parameter int ADDR_W          = $clog2(NUM_FRAMES * SPR_W * SPR_H),
    localparam int FRAME_W        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                 vga_clk,
    input  logic                 reset_n,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    input  logic                 blank,
    input  logic                 frame_start,
    input  logic [9:0]           pos_x,
    input  logic [9:0]           pos_y,
    input  logic                 flip_h,
    input  logic                 anim_en,
    input  logic                 anim_restart,
    sprite_anim_blitter_if.master bus,
    output logic [3:0]           red,
    output logic [3:0]           green,
    output logic [3:0]           blue,
    output logic                 sprite_on,
    output logic [FRAME_W-1:0]   frame_idx
);
    localparam int COL_W      = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int ROW_W      = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int HOLD_W     = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int FRAME_SIZE = SPR_W * SPR_H;
    localparam logic [10:0] BOX_W = 11'(SPR_W << SCALE_LOG2);
    localparam logic [10:0] BOX_H = 11'(SPR_H << SCALE_LOG2);

    logic [10:0]       dx, dy;
    logic              in_box;
    logic [COL_W-1:0]  col_src, col;
    logic [ROW_W-1:0]  row;
    logic [HOLD_W-1:0] hold;
    logic [ROM_LATENCY-1:0] box_pipe, blank_pipe;
    logic              d_in_box, d_blank;

    // 11-bit differences; the >= terms stop a sprite near the right/bottom edge from wrapping to x=0/y=0.
    assign dx = {1'b0, DrawX} - {1'b0, pos_x};
    assign dy = {1'b0, DrawY} - {1'b0, pos_y};
    assign in_box = (DrawX >= pos_x) && (dx < BOX_W) && (DrawY >= pos_y) && (dy < BOX_H);

    // Power-of-two scaling is just a bit select of the offset.
    assign col_src = dx[SCALE_LOG2 +: COL_W];
    assign row     = dy[SCALE_LOG2 +: ROW_W];
    assign col     = flip_h ? (COL_W'(SPR_W - 1) - col_src) : col_src;

    assign bus.rom_address = in_box ?
        (ADDR_W'(frame_idx) * ADDR_W'(FRAME_SIZE) + ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col)) :
        '0;

    assign bus.pal_index = bus.rom_q;

    // Sideband delay line so in_box/blank line up with the ROM data.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            box_pipe   <= '0;
            blank_pipe <= '0;
        end else begin
            box_pipe[0]   <= in_box;
            blank_pipe[0] <= blank;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                box_pipe[i]   <= box_pipe[i-1];
                blank_pipe[i] <= blank_pipe[i-1];
            end
        end
    end

    assign d_in_box = box_pipe[ROM_LATENCY-1];
    assign d_blank  = blank_pipe[ROM_LATENCY-1];

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            sprite_on <= 1'b0;
        end else if (d_blank && d_in_box && (bus.rom_q != IDX_W'(TRANSPARENT_IDX))) begin
            red       <= bus.palette_red;
            green     <= bus.palette_green;
            blue      <= bus.palette_blue;
            sprite_on <= 1'b1;
        end else begin
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            sprite_on <= 1'b0;
        end
    end

    // Animation only moves on frame_start so a frame never changes mid-screen.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_idx <= '0;
            hold      <= '0;
        end else if (anim_restart) begin
            frame_idx <= '0;
            hold      <= '0;
        end else if (frame_start && anim_en) begin
            if (hold == HOLD_W'(FRAME_HOLD - 1)) begin
                hold      <= '0;
                frame_idx <= (frame_idx == FRAME_W'(NUM_FRAMES - 1)) ? '0 : frame_idx + 1'b1;
            end else begin
                hold <= hold + 1'b1;
            end
        end
    end
endmodule

// File: doc/sprite_anim_blitter.md
Name: sprite_anim_blitter

Overview:
- Parametrised successor to the full-screen single-image ROM renderer.
- Draws an animated, multi-frame sprite at a runtime (pos_x, pos_y) with power-of-two integer scaling, optional horizontal mirror and a transparent colour key.
- Sits in the VGA pixel path between the DrawX/DrawY generator and the colour mux. The sprite ROM and the palette are external, so one blitter serves any asset.
- Exports sprite_on so the downstream compositor can layer several blitters.

Parameters:
- SPR_W, 32, sprite width in source pixels.
- SPR_H, 32, sprite height in source pixels.
- NUM_FRAMES, 4, animation frames stored back-to-back in the ROM, frame-major.
- SCALE_LOG2, 1, on-screen scale = 2^SCALE_LOG2 (0..3).
- FRAME_HOLD, 8, video frames each animation frame is shown (>=1).
- IDX_W, 4, palette index width.
- TRANSPARENT_IDX, 0, ROM index treated as see-through.
- ROM_LATENCY, 1, ROM address-to-q latency in clocks (1..3).
- ADDR_W, derived, clog2(NUM_FRAMES*SPR_W*SPR_H); 12 at defaults.

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video.
- frame_start  in  1  one-cycle pulse at start of vertical blanking.
- pos_x  in  10  sprite left edge, screen pixels.
- pos_y  in  10  sprite top edge, screen pixels.
- flip_h  in  1  mirror horizontally.
- anim_en  in  1  allow animation to advance.
- anim_restart  in  1  synchronous return to frame 0.
- rom_address  out  ADDR_W  to external ROM.
- rom_q  in  IDX_W  ROM data, ROM_LATENCY clocks after address.
- pal_index  out  IDX_W  = rom_q, to external combinational palette.
- palette_red, palette_green, palette_blue  in  4 each  palette output for pal_index.
- red, green, blue  out  4 each  registered pixel colour.
- sprite_on  out  1  registered: opaque sprite pixel present.
- frame_idx  out  clog2(NUM_FRAMES)  current animation frame.

Behaviour:
- Reset: red, green, blue and sprite_on = 0; frame_idx = 0; hold counter = 0; all pipeline sideband registers = 0. Reset is asynchronous assert and synchronous release. A reset mid-line blanks output until the pipeline refills; no X may propagate.
- Geometry (combinational, same cycle as DrawX/DrawY):
  - dx = DrawX - pos_x, dy = DrawY - pos_y, computed in 11 bits.
  - in_box = DrawX >= pos_x && dx < (SPR_W<<SCALE_LOG2) && DrawY >= pos_y && dy < (SPR_H<<SCALE_LOG2).
  - Right and bottom edges clip at 639/479 naturally; no wrap to the left or top.
- Addressing:
  - col = dx >> SCALE_LOG2, row = dy >> SCALE_LOG2; if flip_h, col = SPR_W-1-col.
  - rom_address = frame_idx*SPR_W*SPR_H + row*SPR_W + col when in_box, else 0.
  - Multiplies are by constants only; no dividers.
- Pipeline:
  - {in_box, blank} is delayed ROM_LATENCY stages to align with rom_q.
  - Output register: if d_blank && d_in_box && rom_q != TRANSPARENT_IDX, then colour = palette_*, sprite_on = 1; else colour = 0, sprite_on = 0.
  - Total latency from DrawX/DrawY to red/green/blue/sprite_on = ROM_LATENCY+1 clocks.
- Animation counter:
  - Updates only on cycles where frame_start=1, so a frame never tears mid-screen.
  - anim_restart=1 (any cycle): frame_idx = 0, hold = 0. This has priority over advance, including when both occur in the same cycle.
  - Else if frame_start && anim_en: if hold == FRAME_HOLD-1, hold = 0 and frame_idx advances. Otherwise hold increments.
  - frame_idx advance wraps NUM_FRAMES-1 -> 0.
  - With anim_en=0, frame_idx and hold freeze and are not cleared.
  - With FRAME_HOLD=1, the frame advances on every frame_start.
- Runtime input sampling: pos_x, pos_y and flip_h are used live. The driver changes them only during blanking; changes mid-line take effect on the next pixel with no glitch protection.

Test Plan:
- Reset check: assert reset_n=0 mid-line -> red/green/blue and sprite_on = 0 immediately; frame_idx = 0. After release, the first valid pixel appears ROM_LATENCY+1 clocks after an in-box DrawX.
- Placement and scale at defaults: pos=(100,50), DrawX=100..163 on DrawY=50. Expect rom_address 0,0,1,1,...,31,31 and sprite_on high for x=100..163 after 2-cycle latency. DrawX=164 -> sprite_on=0, rom_address=0.
- Flip and frames: flip_h=1, frame_idx=2, DrawX=pos_x, DrawY=pos_y+2 -> rom_address = 2048+32+31 = 2111.
- Transparency: ROM returns 0 at an in-box pixel -> colour 0 and sprite_on 0. ROM returns 5 -> palette entry 5 is output and sprite_on=1. The same pixel with blank=0 -> colour 0.
- Animation: anim_en=1 with 33 frame_start pulses -> frame_idx sequence 0,1,2,3,0 at pulses 8,16,24,32 and value 0 after pulse 32. anim_en=0 -> holds. anim_restart together with frame_start -> 0.
- Edge clip: pos_x=620 -> sprite_on for DrawX 620..639 only, with no wrap at x=0; ROM_LATENCY=3 build -> latency 4 clocks.
